// File: rtl/nv_nvdla_csb_initiator.sv
// Single-outstanding CSB request initiator: packs host commands into csb2mcif
// request packets and returns the mcif2csb response (or a timeout) as a completion pulse.
module nv_nvdla_csb_initiator #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        nvdla_core_clk,
   input  logic        nvdla_core_rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [21:0] cmd_addr,
   input  logic [31:0] cmd_wdat,
   input  logic [3:0]  cmd_wrbe,
   input  logic        cmd_write,
   input  logic        cmd_nposted,
   output logic        csb2mcif_req_pvld,
   input  logic        csb2mcif_req_prdy,
   output logic [62:0] csb2mcif_req_pd,
   input  logic        mcif2csb_resp_valid,
   input  logic [33:0] mcif2csb_resp_pd,
   output logic        done_valid,
   output logic [31:0] done_rdata,
   output logic        done_error,
   output logic        done_timeout,
   output logic        busy,
   output logic        unexp_rsp,
   input  logic        unexp_clr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [15:0] TERM_CNT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [62:0] pkt_q, pkt_d;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;
   logic        timeout_q, timeout_d;
   logic        unexp_q, unexp_d;
   logic        pkt_write, pkt_nposted;

   assign pkt_write   = pkt_q[54];
   assign pkt_nposted = pkt_q[55];
   assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      pkt_d     = pkt_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      error_d   = error_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               // reads carry no data/byte-enables and always expect a response
               pkt_d = {2'b00, cmd_wrbe & {4{cmd_write}}, 1'b0, cmd_nposted | ~cmd_write,
                        cmd_write, cmd_wdat & {32{cmd_write}}, cmd_addr};
               state_d = REQ;
            end
         end
         REQ: begin
            if (csb2mcif_req_prdy) begin
               if (pkt_write && !pkt_nposted) begin
                  state_d   = DONE;
                  rdata_d   = 32'h0;
                  error_d   = 1'b0;
                  timeout_d = 1'b0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 16'h0;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_inc;
            // a response on the terminal-count cycle takes priority over the timeout
            if (mcif2csb_resp_valid) begin
               state_d   = DONE;
               rdata_d   = mcif2csb_resp_pd[31:0];
               error_d   = mcif2csb_resp_pd[32] | (mcif2csb_resp_pd[33] != pkt_write);
               timeout_d = 1'b0;
            end else if (cnt_inc == TERM_CNT) begin
               state_d   = DONE;
               rdata_d   = 32'h0;
               error_d   = 1'b1;
               timeout_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      unexp_d = (unexp_q & ~unexp_clr) | (mcif2csb_resp_valid & (state_q != WAIT));
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q   <= IDLE;
         pkt_q     <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         error_q   <= 1'b0;
         timeout_q <= 1'b0;
         unexp_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pkt_q     <= pkt_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         error_q   <= error_d;
         timeout_q <= timeout_d;
         unexp_q   <= unexp_d;
      end
   end

   // held low while reset is asserted, high from the first IDLE cycle after release
   assign cmd_ready         = nvdla_core_rstn & (state_q == IDLE);
   assign csb2mcif_req_pvld = (state_q == REQ);
   assign csb2mcif_req_pd   = pkt_q;
   assign done_valid        = (state_q == DONE);
   assign done_rdata        = rdata_q;
   assign done_error        = error_q;
   assign done_timeout      = timeout_q;
   assign busy              = (state_q != IDLE);
   assign unexp_rsp         = unexp_q;

endmodule

// File: tb/tb_nv_nvdla_csb_initiator.sv
// Directed, table-driven bench for nv_nvdla_csb_initiator (TIMEOUT_CYCLES=8),
// plus hand sequences for unexpected responses and mid-transaction reset.
module tb_nv_nvdla_csb_initiator;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [21:0] cmd_addr = '0;
   logic [31:0] cmd_wdat = '0;
   logic [3:0]  cmd_wrbe = '0;
   logic        cmd_write = 1'b0;
   logic        cmd_nposted = 1'b0;
   logic        pvld;
   logic        prdy = 1'b1;
   logic [62:0] pd;
   logic        rv = 1'b0;
   logic [33:0] rpd = '0;
   logic        done_valid;
   logic [31:0] done_rdata;
   logic        done_error;
   logic        done_timeout;
   logic        busy;
   logic        unexp_rsp;
   logic        unexp_clr = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   nv_nvdla_csb_initiator #(.TIMEOUT_CYCLES(8)) dut (
      .nvdla_core_clk(clk),
      .nvdla_core_rstn(rstn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr),
      .cmd_wdat(cmd_wdat),
      .cmd_wrbe(cmd_wrbe),
      .cmd_write(cmd_write),
      .cmd_nposted(cmd_nposted),
      .csb2mcif_req_pvld(pvld),
      .csb2mcif_req_prdy(prdy),
      .csb2mcif_req_pd(pd),
      .mcif2csb_resp_valid(rv),
      .mcif2csb_resp_pd(rpd),
      .done_valid(done_valid),
      .done_rdata(done_rdata),
      .done_error(done_error),
      .done_timeout(done_timeout),
      .busy(busy),
      .unexp_rsp(unexp_rsp),
      .unexp_clr(unexp_clr)
   );

   typedef struct {
      logic [21:0] addr;
      logic [31:0] wdat;
      logic [3:0]  wrbe;
      logic        write;
      logic        nposted;
      int          stall;     // cycles prdy held low while pvld=1
      int          rsp_dly;   // response in cycle H+rsp_dly after handshake H; 0 = none
      logic [33:0] rsp_pd;
      logic [62:0] exp_pd;
      int          exp_lat;   // done_valid in cycle H+exp_lat
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_tmo;
   } vec_t;

   vec_t tbl[9];

   function automatic vec_t mk(input logic [21:0] a, input logic [31:0] wd, input logic [3:0] be,
                               input logic w, input logic np, input int st, input int dly,
                               input logic [33:0] rp, input logic [62:0] epd, input int lat,
                               input logic [31:0] erd, input logic ee, input logic et);
      vec_t v;
      v.addr = a; v.wdat = wd; v.wrbe = be; v.write = w; v.nposted = np;
      v.stall = st; v.rsp_dly = dly; v.rsp_pd = rp; v.exp_pd = epd; v.exp_lat = lat;
      v.exp_rdata = erd; v.exp_err = ee; v.exp_tmo = et;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int lat;
      cmd_addr = v.addr; cmd_wdat = v.wdat; cmd_wrbe = v.wrbe;
      cmd_write = v.write; cmd_nposted = v.nposted; cmd_valid = 1'b1;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      tick();
      cmd_valid = 1'b0;
      cmd_wdat = 32'h0BAD_F00D;
      cmd_addr = 22'h155555;
      if (v.stall > 0) prdy = 1'b0;
      for (int s = 0; s <= v.stall; s++) begin
         if (s == v.stall) prdy = 1'b1;
         chk("req_pvld", 64'(pvld), 64'(1));
         chk("req_pd", 64'(pd), 64'(v.exp_pd));
         chk("req_busy", 64'(busy), 64'(1));
         if (s != v.stall) tick();
      end
      tick();
      lat = 1;
      while (!done_valid && lat < 20) begin
         if (v.rsp_dly != 0 && lat == v.rsp_dly) begin
            rv = 1'b1;
            rpd = v.rsp_pd;
         end
         tick();
         rv = 1'b0;
         lat++;
      end
      chk("done_valid", 64'(done_valid), 64'(1));
      chk("done_lat", 64'(lat), 64'(v.exp_lat));
      chk("done_rdata", 64'(done_rdata), 64'(v.exp_rdata));
      chk("done_error", 64'(done_error), 64'(v.exp_err));
      chk("done_timeout", 64'(done_timeout), 64'(v.exp_tmo));
      $display("txn %0d: addr=%h write=%0d lat=%0d rdata=%h err=%0d tmo=%0d",
               id, v.addr, v.write, lat, done_rdata, done_error, done_timeout);
      tick();
      chk("done_pulse_end", 64'(done_valid), 64'(0));
      chk("idle_ready", 64'(cmd_ready), 64'(1));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("rdata_hold", 64'(done_rdata), 64'(v.exp_rdata));
      chk("no_unexp", 64'(unexp_rsp), 64'(0));
   endtask

   task automatic reset_mid(input bit in_wait);
      cmd_addr = 22'h000044; cmd_write = 1'b0; cmd_nposted = 1'b0; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      prdy = in_wait;
      tick();
      if (in_wait) chk("pre_rst_wait_busy", 64'(busy), 64'(1));
      else chk("pre_rst_req_pvld", 64'(pvld), 64'(1));
      #2;
      rstn = 1'b0;
      #1;
      chk("rst_pvld", 64'(pvld), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done_valid), 64'(0));
      chk("rst_ready", 64'(cmd_ready), 64'(0));
      prdy = 1'b1;
      tick();
      rstn = 1'b1;
      #1;
      chk("rel_ready", 64'(cmd_ready), 64'(1));
      rv = 1'b1;
      rpd = {1'b0, 1'b0, 32'hFEED_0001};
      tick();
      rv = 1'b0;
      chk("post_rst_unexp", 64'(unexp_rsp), 64'(1));
      $display("reset during %s: pvld/busy dropped, late response flagged", in_wait ? "WAIT" : "REQ");
      unexp_clr = 1'b1;
      tick();
      unexp_clr = 1'b0;
      run_vec(100 + int'(in_wait), tbl[0]);
   endtask

   initial begin
      tbl[0] = mk(22'h000004, 32'h0, 4'h0, 1'b0, 1'b0, 0, 2, {1'b0, 1'b0, 32'h0000_0F0F},
                  {2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 22'h000004}, 3, 32'h0000_0F0F, 1'b0, 1'b0);
      tbl[1] = mk(22'h000008, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b0, 3, 0, 34'h0,
                  {2'b00, 4'hF, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, 22'h000008}, 1, 32'h0, 1'b0, 1'b0);
      tbl[2] = mk(22'h000010, 32'h1234_5678, 4'h3, 1'b1, 1'b1, 0, 1, {1'b1, 1'b1, 32'hDEAD_BEEF},
                  {2'b00, 4'h3, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 22'h000010}, 2, 32'hDEAD_BEEF, 1'b1, 1'b0);
      tbl[3] = mk(22'h3FFFFF, 32'h0000_FFFF, 4'h5, 1'b1, 1'b1, 1, 3, {1'b0, 1'b0, 32'h1111_2222},
                  {2'b00, 4'h5, 1'b0, 1'b1, 1'b1, 32'h0000_FFFF, 22'h3FFFFF}, 4, 32'h1111_2222, 1'b1, 1'b0);
      tbl[4] = mk(22'h2AAAAA, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 0, 1, {1'b0, 1'b0, 32'hCAFE_F00D},
                  {2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 22'h2AAAAA}, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
      tbl[5] = mk(22'h000100, 32'h0, 4'h0, 1'b0, 1'b0, 0, 4, {1'b1, 1'b0, 32'h5555_AAAA},
                  {2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 22'h000100}, 5, 32'h5555_AAAA, 1'b1, 1'b0);
      tbl[6] = mk(22'h000200, 32'h0, 4'h0, 1'b0, 1'b0, 0, 1, {1'b0, 1'b1, 32'h0BAD_0BAD},
                  {2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 22'h000200}, 2, 32'h0BAD_0BAD, 1'b1, 1'b0);
      tbl[7] = mk(22'h000020, 32'h0, 4'h0, 1'b0, 1'b0, 0, 7, {1'b0, 1'b0, 32'h0000_7777},
                  {2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 22'h000020}, 8, 32'h0000_7777, 1'b0, 1'b0);
      tbl[8] = mk(22'h000040, 32'h0, 4'h0, 1'b0, 1'b0, 0, 0, 34'h0,
                  {2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 22'h000040}, 8, 32'h0, 1'b1, 1'b1);

      #12;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst_pvld", 64'(pvld), 64'(0));
      chk("rst_pd", 64'(pd), 64'(0));
      chk("rst_done_valid", 64'(done_valid), 64'(0));
      chk("rst_done_rdata", 64'(done_rdata), 64'(0));
      chk("rst_done_error", 64'(done_error), 64'(0));
      chk("rst_done_timeout", 64'(done_timeout), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_unexp", 64'(unexp_rsp), 64'(0));
      tick();
      rstn = 1'b1;
      #1;
      chk("first_idle_ready", 64'(cmd_ready), 64'(1));

      for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

      // late response two cycles after the timeout completion
      tick();
      rv = 1'b1;
      rpd = {1'b0, 1'b0, 32'h0000_1234};
      tick();
      rv = 1'b0;
      chk("late_rsp_unexp", 64'(unexp_rsp), 64'(1));
      chk("late_rsp_no_busy", 64'(busy), 64'(0));
      unexp_clr = 1'b1;
      tick();
      unexp_clr = 1'b0;
      chk("unexp_cleared", 64'(unexp_rsp), 64'(0));
      $display("late response after timeout: flagged then cleared");

      // simultaneous set and clear while idle
      rv = 1'b1;
      unexp_clr = 1'b1;
      tick();
      rv = 1'b0;
      unexp_clr = 1'b0;
      chk("set_clr_same_cycle", 64'(unexp_rsp), 64'(1));
      unexp_clr = 1'b1;
      tick();
      unexp_clr = 1'b0;
      chk("unexp_cleared2", 64'(unexp_rsp), 64'(0));
      $display("response with clear in same cycle: flag stays set");

      reset_mid(1'b0);
      reset_mid(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
